// File: rtl/irq_encoder16.sv
// Registered 16-input priority encoder: edge-captured pending requests, mask,
// and a valid/ack handshake presenting the lowest eligible index one at a time.
module irq_encoder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        mask_we,
    input  logic [15:0] mask_in,
    input  logic        ack,
    input  logic        clr_ovf,
    output logic        A3,
    output logic        A2,
    output logic        A1,
    output logic        A0,
    output logic        valid,
    output logic [15:0] pending,
    output logic        ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] req_q, req_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] mask_q, mask_d;
    logic [3:0]  a_q, a_d;
    logic        ovf_q, ovf_d;

    logic [15:0] rise;
    logic [15:0] clear;
    logic [15:0] elig;
    logic        ack_acc;

    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            a_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            a_q       <= a_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state and datapath logic.
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        req_d     = req;
        mask_d    = mask_we ? mask_in : mask_q;

        ack_acc   = ack && (state_q == PRESENT);
        rise      = req & ~req_q;
        clear     = ack_acc ? (16'h0001 << a_q) : 16'h0000;
        elig      = pending_q & ~mask_q;

        // A rising edge on a bit being acked in the same cycle re-arms it.
        pending_d = (pending_q & ~clear) | rise;
        ovf_d     = (ovf_q & ~clr_ovf) | (|(rise & pending_q & ~clear));

        unique case (state_q)
            IDLE: begin
                if (elig != 16'h0000) begin
                    a_d     = lowest_index(elig);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are direct decodes of registers only.
    always_comb begin
        valid   = (state_q == PRESENT);
        A3      = a_q[3];
        A2      = a_q[2];
        A1      = a_q[1];
        A0      = a_q[0];
        pending = pending_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_irq_encoder16.sv
// Directed self-checking bench for irq_encoder16; each task drives one
// scenario and compares outputs 1 time unit after the rising edge.
module tb_irq_encoder16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        mask_we;
    logic [15:0] mask_in;
    logic        ack;
    logic        clr_ovf;
    logic        A3, A2, A1, A0;
    logic        valid;
    logic [15:0] pending;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    wire [3:0] a_idx = {A3, A2, A1, A0};

    irq_encoder16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ack     (ack),
        .clr_ovf (clr_ovf),
        .A3      (A3),
        .A2      (A2),
        .A1      (A1),
        .A0      (A0),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; mask_we = 1'b0; mask_in = '0; ack = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL reset_pending got=%h exp=0000", pending); end
        checks++; if (a_idx !== 4'd0) begin failures++; $display("FAIL reset_a got=%0d exp=0", a_idx); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_single();
        req = 16'h0020; tick(); req = '0;
        checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL single_pending got=%h exp=0020", pending); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd5) begin failures++; $display("FAIL single_present got valid=%b a=%0d exp valid=1 a=5", valid, a_idx); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (valid !== 1'b0 || pending !== 16'h0000) begin failures++; $display("FAIL single_ack got valid=%b pending=%h exp valid=0 pending=0000", valid, pending); end
    endtask

    task automatic test_priority();
        logic [3:0]  exp_idx [3];
        logic [15:0] exp_pend [3];
        exp_idx  = '{4'd0, 4'd4, 4'd15};
        exp_pend = '{16'h8010, 16'h8000, 16'h0000};
        req = 16'h8011; tick(); req = '0;
        checks++; if (pending !== 16'h8011) begin failures++; $display("FAIL prio_pending got=%h exp=8011", pending); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid !== 1'b1 || a_idx !== exp_idx[i]) begin failures++; $display("FAIL prio_present%0d got valid=%b a=%0d exp valid=1 a=%0d", i, valid, a_idx, exp_idx[i]); end
            ack = 1'b1; tick(); ack = 1'b0;
            checks++; if (valid !== 1'b0 || pending !== exp_pend[i]) begin failures++; $display("FAIL prio_ack%0d got valid=%b pending=%h exp valid=0 pending=%h", i, valid, pending, exp_pend[i]); end
        end
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL prio_idle got=%b exp=0", valid); end
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_in = 16'h0001; tick(); mask_we = 1'b0;
        req = 16'h0003; tick(); req = '0;
        tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd1) begin failures++; $display("FAIL mask_present got valid=%b a=%0d exp valid=1 a=1", valid, a_idx); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (valid !== 1'b0 || pending !== 16'h0001) begin failures++; $display("FAIL mask_ack got valid=%b pending=%h exp valid=0 pending=0001", valid, pending); end
        // Ack while idle must not clear anything.
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (valid !== 1'b0 || pending !== 16'h0001) begin failures++; $display("FAIL mask_blocked got valid=%b pending=%h exp valid=0 pending=0001", valid, pending); end
        mask_we = 1'b1; mask_in = 16'h0000; tick(); mask_we = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mask_write_edge got valid=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd0) begin failures++; $display("FAIL mask_unmask got valid=%b a=%0d exp valid=1 a=0", valid, a_idx); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL mask_final got pending=%h exp=0000", pending); end
    endtask

    task automatic test_overrun();
        req = 16'h0008; tick(); req = '0; tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd3) begin failures++; $display("FAIL ovr_present got valid=%b a=%0d exp valid=1 a=3", valid, a_idx); end
        req = 16'h0008; tick(); req = '0; tick();
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovr_first got=%b exp=1", ovf); end
        // Second overrun coincides with clr_ovf: the new overrun wins.
        req = 16'h0008; clr_ovf = 1'b1; tick(); req = '0; clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovr_clr_collide got=%b exp=1", ovf); end
        tick();
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovf); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovf); end
        checks++; if (valid !== 1'b1 || a_idx !== 4'd3) begin failures++; $display("FAIL ovr_hold got valid=%b a=%0d exp valid=1 a=3", valid, a_idx); end
    endtask

    task automatic test_set_wins();
        req = 16'h0008; ack = 1'b1; tick(); req = '0; ack = 1'b0;
        checks++; if (pending !== 16'h0008 || ovf !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL setwins got pending=%h ovf=%b valid=%b exp pending=0008 ovf=0 valid=0", pending, ovf, valid); end
        tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd3) begin failures++; $display("FAIL setwins_repr got valid=%b a=%0d exp valid=1 a=3", valid, a_idx); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL setwins_final got pending=%h exp=0000", pending); end
    endtask

    task automatic test_reset_mid();
        req = 16'h0180; tick();
        req = 16'h0080; tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd7 || pending !== 16'h0180) begin failures++; $display("FAIL rmid_setup got valid=%b a=%0d pending=%h exp valid=1 a=7 pending=0180", valid, a_idx, pending); end
        rst_n = 1'b0; tick();
        checks++; if (valid !== 1'b0 || pending !== 16'h0000 || a_idx !== 4'd0 || ovf !== 1'b0) begin failures++; $display("FAIL rmid_reset got valid=%b pending=%h a=%0d ovf=%b exp all 0", valid, pending, a_idx, ovf); end
        rst_n = 1'b1; tick();
        checks++; if (valid !== 1'b0 || pending !== 16'h0080) begin failures++; $display("FAIL rmid_edge got valid=%b pending=%h exp valid=0 pending=0080", valid, pending); end
        tick();
        checks++; if (valid !== 1'b1 || a_idx !== 4'd7) begin failures++; $display("FAIL rmid_present got valid=%b a=%0d exp valid=1 a=7", valid, a_idx); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (valid !== 1'b0 || pending !== 16'h0000) begin failures++; $display("FAIL rmid_ack got valid=%b pending=%h exp valid=0 pending=0000", valid, pending); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_overrun();
        test_set_wins();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
